// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, control-field encodings and controller states shared by the CPU decoders.
package cpu_ctrl_pkg;
   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_BEQ   = 6'd1;
   localparam logic [5:0] OP_LW    = 6'd2;
   localparam logic [5:0] OP_SW    = 6'd3;
   localparam logic [5:0] OP_ADDI  = 6'd4;
   localparam logic [5:0] OP_ANDI  = 6'd5;
   localparam logic [5:0] OP_ORI   = 6'd6;
   localparam logic [5:0] OP_SLTI  = 6'd7;
   localparam logic [5:0] OP_J     = 6'd8;
   localparam logic [5:0] OP_JAL   = 6'd9;
   localparam logic [5:0] OP_JR    = 6'd10;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_IMM   = 2'b10;
   localparam logic [1:0] ALU_FUNCT = 2'b11;

   localparam logic [1:0] SRCB_RT     = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] PCS_RS     = 2'b11;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR, S_MEM_READ,
      S_WB_MEM, S_MEM_WRITE, S_BRANCH, S_JUMP, S_JAL, S_JR, S_ILLEGAL
   } ctrl_state_t;
endpackage

// File: rtl/multicycle_control.sv
// multicycle_control: per-instruction state walk driving the shared-ALU, unified-memory datapath.
module multicycle_control
   import cpu_ctrl_pkg::*;
#(
   parameter bit STRICT_DECODE = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic [1:0] pc_source,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       link,
   output logic       instr_done,
   output logic       illegal_op
);
   ctrl_state_t state_q, state_d, decode_d;
   logic        unused_zero;

   // the zero flag qualifies pc_write_cond inside the datapath, not here
   assign unused_zero = zero;

   assign decode_d = (opcode == OP_RTYPE)                  ? S_EXEC_R   :
                     (opcode == OP_BEQ)                    ? S_BRANCH   :
                     (opcode == OP_LW || opcode == OP_SW)  ? S_MEM_ADDR :
                     (opcode inside {[OP_ADDI:OP_SLTI]})   ? S_EXEC_I   :
                     (opcode == OP_J)                      ? S_JUMP     :
                     (opcode == OP_JAL)                    ? S_JAL      :
                     (opcode == OP_JR)                     ? S_JR       :
                     STRICT_DECODE                         ? S_ILLEGAL  : S_EXEC_R;

   always_ff @(posedge clk) state_q <= rst ? S_FETCH : state_d;

   always_comb begin
      state_d       = S_FETCH;
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      iord          = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = PCS_ALU;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_RT;
      alu_op        = ALU_ADD;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      link          = 1'b0;
      instr_done    = 1'b0;
      illegal_op    = 1'b0;
      if (!rst)
         case (state_q)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               state_d   = mem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
               alu_src_b = SRCB_IMM_SH;
               state_d   = decode_d;
            end
            S_EXEC_R: begin
               alu_src_a = 1'b1;
               alu_op    = ALU_FUNCT;
               state_d   = S_WB_R;
            end
            S_WB_R: begin
               reg_write  = 1'b1;
               reg_dst    = 1'b1;
               instr_done = 1'b1;
            end
            S_EXEC_I: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               alu_op    = (opcode == OP_ADDI) ? ALU_ADD : ALU_IMM;
               state_d   = S_WB_I;
            end
            S_WB_I: begin
               reg_write  = 1'b1;
               instr_done = 1'b1;
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = SRCB_IMM;
               state_d   = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
            end
            S_MEM_READ: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               state_d = mem_ready ? S_WB_MEM : S_MEM_READ;
            end
            S_WB_MEM: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
               mem_req    = 1'b1;
               mem_we     = 1'b1;
               iord       = 1'b1;
               instr_done = mem_ready;
               state_d    = mem_ready ? S_FETCH : S_MEM_WRITE;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu_op        = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_source     = PCS_ALUOUT;
               instr_done    = 1'b1;
            end
            S_JUMP: begin
               pc_write   = 1'b1;
               pc_source  = PCS_JUMP;
               instr_done = 1'b1;
            end
            S_JAL: begin
               reg_write  = 1'b1;
               link       = 1'b1;
               pc_write   = 1'b1;
               pc_source  = PCS_JUMP;
               instr_done = 1'b1;
            end
            S_JR: begin
               pc_write   = 1'b1;
               pc_source  = PCS_RS;
               instr_done = 1'b1;
            end
            S_ILLEGAL: illegal_op = 1'b1;
            default: state_d = S_FETCH;
         endcase
   end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: random instruction streams against a per-instruction cycle-sequence model.
module tb_multicycle_control;
   localparam int MREQ = 18, MWE = 17, IORD = 16, IRW = 15, PCW = 14, PCWC = 13, PCS = 11;
   localparam int ASA = 10, ASB = 8, AOP = 6, RW = 5, RD = 4, M2R = 3, LNK = 2, DONE = 1, ILL = 0;

   typedef struct packed {
      logic        rdy;
      logic [18:0] w;
   } step_t;

   logic        clk = 1'b0;
   logic        rst_v [2];
   logic        zero_v [2];
   logic        rdy_v [2];
   logic [5:0]  op_v [2];
   logic [18:0] obs [2];
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic       mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, alu_src_a;
      logic       reg_write, reg_dst, mem_to_reg, link, instr_done, illegal_op;
      logic [1:0] pc_source, alu_src_b, alu_op;
      multicycle_control #(.STRICT_DECODE(g == 0)) u_dut (
         .clk(clk), .rst(rst_v[g]), .opcode(op_v[g]), .zero(zero_v[g]), .mem_ready(rdy_v[g]),
         .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
         .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_source(pc_source),
         .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
         .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .link(link),
         .instr_done(instr_done), .illegal_op(illegal_op)
      );
      assign obs[g] = {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond, pc_source,
                       alu_src_a, alu_src_b, alu_op, reg_write, reg_dst, mem_to_reg, link,
                       instr_done, illegal_op};
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One instruction: build the expected cycle list, then drive and compare it.
   // abort >= 0 asserts reset at that cycle index instead of finishing the instruction.
   task automatic run(input int d, input logic [5:0] op, input bit z, input int wf, input int wm,
                      input int abort);
      step_t       q[$];
      logic [18:0] w, fw;
      int          k, lat, seen;
      bit          strict;
      strict = (d == 0);
      k = (op <= 6'd10) ? int'(op) : (strict ? 11 : 0);
      fw = '0; fw[MREQ] = 1; fw[ASB+:2] = 2'b01;
      for (int i = 0; i < wf; i++) q.push_back({1'b0, fw});
      w = fw; w[IRW] = 1; w[PCW] = 1; q.push_back({1'b1, w});
      w = '0; w[ASB+:2] = 2'b11; q.push_back({1'($urandom), w});
      if (k == 0 || (k >= 4 && k <= 7)) begin
         w = '0; w[ASA] = 1;
         w[ASB+:2] = (k == 0) ? 2'b00 : 2'b10;
         w[AOP+:2] = (k == 0) ? 2'b11 : (k == 4) ? 2'b00 : 2'b10;
         q.push_back({1'($urandom), w});
         w = '0; w[RW] = 1; w[RD] = (k == 0); w[DONE] = 1; q.push_back({1'($urandom), w});
      end else if (k == 2 || k == 3) begin
         w = '0; w[ASA] = 1; w[ASB+:2] = 2'b10; q.push_back({1'($urandom), w});
         w = '0; w[MREQ] = 1; w[IORD] = 1; w[MWE] = (k == 3);
         for (int i = 0; i < wm; i++) q.push_back({1'b0, w});
         w[DONE] = (k == 3); q.push_back({1'b1, w});
         if (k == 2) begin
            w = '0; w[RW] = 1; w[M2R] = 1; w[DONE] = 1; q.push_back({1'($urandom), w});
         end
      end else begin
         w = '0;
         if (k == 1) begin w[ASA] = 1; w[AOP+:2] = 2'b01; w[PCWC] = 1; w[PCS+:2] = 2'b01; end
         if (k == 8 || k == 9) begin w[PCW] = 1; w[PCS+:2] = 2'b10; end
         if (k == 9) begin w[RW] = 1; w[LNK] = 1; end
         if (k == 10) begin w[PCW] = 1; w[PCS+:2] = 2'b11; end
         w[DONE] = (k != 11); w[ILL] = (k == 11);
         q.push_back({1'($urandom), w});
      end
      lat = wf + ((k == 2) ? 5 + wm : (k == 3) ? 4 + wm : (k == 0 || (k >= 4 && k <= 7)) ? 4 : 3);
      seen = -1;
      foreach (q[i]) begin
         rdy_v[d] = q[i].rdy;
         op_v[d] = (i <= wf) ? 6'($urandom) : op;
         zero_v[d] = z;
         if (i == abort) begin
            rst_v[d] = 1'b1;
            @(negedge clk);
            check($sformatf("abort_rst d%0d", d), 32'(obs[d]), 32'd0);
            @(posedge clk); #1;
            rst_v[d] = 1'b0; rdy_v[d] = 1'b0;
            @(negedge clk);
            check($sformatf("abort_fetch d%0d", d), 32'(obs[d]), 32'(fw));
            @(posedge clk); #1;
            return;
         end
         @(negedge clk);
         check($sformatf("seq d%0d op%0d cyc%0d", d, op, i), 32'(obs[d]), 32'(q[i].w));
         if (seen < 0 && (obs[d][DONE] || obs[d][ILL])) seen = i + 1;
         @(posedge clk); #1;
      end
      check($sformatf("latency d%0d op%0d", d, op), 32'(seen), 32'(lat));
   endtask

   task automatic run_rand(input int d);
      int r;
      r = $urandom_range(0, 13);
      run(d, (r <= 10) ? 6'(r) : 6'($urandom_range(11, 63)), 1'($urandom),
          $urandom_range(0, 2), $urandom_range(0, 3), -1);
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_v[d] = 1'b1; rdy_v[d] = 1'b0; zero_v[d] = 1'b0; op_v[d] = '0;
      end
      repeat (2) begin
         @(posedge clk); #1;
         rdy_v[0] = 1'($urandom);
         @(negedge clk);
         check("reset_outputs", 32'(obs[0]), 32'd0);
      end
      @(posedge clk); #1;
      rst_v[0] = 1'b0;
      run(0, 6'd4, 1'b0, 2, 0, -1);
      run(0, 6'd4, 1'b0, 0, 0, -1);
      run(0, 6'd2, 1'b0, 0, 3, -1);
      run(0, 6'd1, 1'b1, 0, 0, -1);
      run(0, 6'd1, 1'b0, 0, 0, -1);
      run(0, 6'd9, 1'b0, 0, 0, -1);
      run(0, 6'd10, 1'b0, 0, 0, -1);
      run(0, 6'h3F, 1'b0, 0, 0, -1);
      run(0, 6'd3, 1'b0, 0, 0, -1);
      run(0, 6'd3, 1'b0, 1, 2, 4);
      run(0, 6'd0, 1'b0, 0, 0, -1);
      repeat (80) run_rand(0);
      rst_v[1] = 1'b0;
      run(1, 6'h3F, 1'b0, 0, 0, -1);
      run(1, 6'd11, 1'b1, 1, 0, -1);
      repeat (30) run_rand(1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
